// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - grant encodings, state encoding and address width for bus_arbiter
package bus_arbiter_pkg;

    // Serial slave address width (bits shifted in per connection).
    localparam int SLAVE_ADDR_W = 2;

    // Master grant encodings; 2'b11 is never driven.
    localparam logic [1:0] BUS_GRANT_NONE = 2'b00;
    localparam logic [1:0] BUS_GRANT_M1   = 2'b01;
    localparam logic [1:0] BUS_GRANT_M2   = 2'b10;

    // Slave grant encodings: {slave_id, connected}.
    localparam logic [2:0] SLAVE_GRANT_NONE = 3'b000;
    localparam logic [2:0] SLAVE_GRANT_S1   = 3'b011;
    localparam logic [2:0] SLAVE_GRANT_S2   = 3'b101;
    localparam logic [2:0] SLAVE_GRANT_S3   = 3'b111;

    // Arbiter states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_CONNECT  = 2'd2,
        ST_WAIT_REL = 2'd3
    } arb_state_e;

    // Map a captured slave address onto the slave grant bus.
    function automatic logic [2:0] slave_grant_of(input logic [SLAVE_ADDR_W-1:0] addr);
        case (addr)
            2'b01:   return SLAVE_GRANT_S1;
            2'b10:   return SLAVE_GRANT_S2;
            2'b11:   return SLAVE_GRANT_S3;
            default: return SLAVE_GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_timeout_cnt.sv
// rtl/bus_arbiter_timeout_cnt.sv - arb_timeout_cnt: slave-not-ready counter with terminal-count pulse
module arb_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // Terminal value: the count of earlier not-ready cycles when the current one is the last allowed.
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // tc fires on the cycle that makes the consecutive not-ready run reach TIMEOUT.
    assign tc_o = en_i && !clr_i && (cnt_q == TC_VAL);

    // Next count: clear wins, wrap to zero after the terminal cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master three-slave serial bus arbiter; optional slave timeout via ARB_TIMEOUT_EN
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_addr,
    input  logic       m2_addr,
    input  logic       m1_addr_valid,
    input  logic       m2_addr_valid,
    input  logic       slave_ready_1,
    input  logic       slave_ready_2,
    input  logic       slave_ready_3,
    output logic [1:0] bus_grant,
    output logic [2:0] slave_grant,
    output logic       addr_err,
    output logic       arb_timeout
);

    arb_state_e state_q;
    logic [1:0] bus_grant_q;
    logic [2:0] slave_grant_q;
    logic       addr_err_q;
    logic       arb_timeout_q;
    logic       shift_cnt_q;   // 0: expecting first address bit, 1: expecting second
    logic       addr_hi_q;     // first (MSB) address bit
    logic       owner_q;       // master holding or last holding the bus: 0 = M1, 1 = M2
    logic       last_grant_q;  // round-robin memory: 0 = M1, 1 = M2

    logic       sel_req;
    logic       sel_addr;
    logic       sel_valid;
    logic       timeout_fire;

    // Only the owning master's request and address lines are observed.
    assign sel_req   = owner_q ? m2_req        : m1_req;
    assign sel_addr  = owner_q ? m2_addr       : m1_addr;
    assign sel_valid = owner_q ? m2_addr_valid : m1_addr_valid;

`ifdef ARB_TIMEOUT_EN
    logic sel_ready;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    // Ready of the slave currently selected by the connection.
    always_comb begin
        sel_ready = 1'b0;
        case (slave_grant_q[2:1])
            2'b01:   sel_ready = slave_ready_1;
            2'b10:   sel_ready = slave_ready_2;
            2'b11:   sel_ready = slave_ready_3;
            default: sel_ready = 1'b0;
        endcase
    end

    assign cnt_clr = (state_q != ST_CONNECT) || sel_ready;
    assign cnt_en  = (state_q == ST_CONNECT) && !sel_ready;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    assign timeout_fire = cnt_tc;
`else
    logic [CNT_W-1:0] unused_tmo_cfg;
    logic             unused_ready;

    assign unused_tmo_cfg = CNT_W'(TIMEOUT);
    assign unused_ready   = slave_ready_1 ^ slave_ready_2 ^ slave_ready_3;
    assign timeout_fire   = 1'b0;
`endif

    // Arbitration FSM with all outputs registered; request drop takes priority over every other event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            bus_grant_q   <= BUS_GRANT_NONE;
            slave_grant_q <= SLAVE_GRANT_NONE;
            addr_err_q    <= 1'b0;
            arb_timeout_q <= 1'b0;
            shift_cnt_q   <= 1'b0;
            addr_hi_q     <= 1'b0;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            addr_err_q    <= 1'b0;
            arb_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    shift_cnt_q <= 1'b0;
                    if (m1_req && m2_req) begin
                        owner_q      <= ~last_grant_q;
                        last_grant_q <= ~last_grant_q;
                        bus_grant_q  <= last_grant_q ? BUS_GRANT_M1 : BUS_GRANT_M2;
                        state_q      <= ST_ADDR;
                    end else if (m1_req) begin
                        owner_q     <= 1'b0;
                        bus_grant_q <= BUS_GRANT_M1;
                        state_q     <= ST_ADDR;
                    end else if (m2_req) begin
                        owner_q     <= 1'b1;
                        bus_grant_q <= BUS_GRANT_M2;
                        state_q     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!sel_req) begin
                        bus_grant_q <= BUS_GRANT_NONE;
                        shift_cnt_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (sel_valid) begin
                        if (!shift_cnt_q) begin
                            addr_hi_q   <= sel_addr;
                            shift_cnt_q <= 1'b1;
                        end else begin
                            shift_cnt_q <= 1'b0;
                            if ({addr_hi_q, sel_addr} == 2'b00) begin
                                addr_err_q  <= 1'b1;
                                bus_grant_q <= BUS_GRANT_NONE;
                                state_q     <= ST_WAIT_REL;
                            end else begin
                                slave_grant_q <= slave_grant_of({addr_hi_q, sel_addr});
                                state_q       <= ST_CONNECT;
                            end
                        end
                    end
                end
                ST_CONNECT: begin
                    if (!sel_req) begin
                        bus_grant_q   <= BUS_GRANT_NONE;
                        slave_grant_q <= SLAVE_GRANT_NONE;
                        state_q       <= ST_IDLE;
                    end else if (timeout_fire) begin
                        arb_timeout_q <= 1'b1;
                        bus_grant_q   <= BUS_GRANT_NONE;
                        slave_grant_q <= SLAVE_GRANT_NONE;
                        state_q       <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    bus_grant_q   <= BUS_GRANT_NONE;
                    slave_grant_q <= SLAVE_GRANT_NONE;
                    if (!sel_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_grant   = bus_grant_q;
    assign slave_grant = slave_grant_q;
    assign addr_err    = addr_err_q;
    assign arb_timeout = arb_timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       m1_req = 1'b0, m2_req = 1'b0;
    logic       m1_addr = 1'b0, m2_addr = 1'b0;
    logic       m1_addr_valid = 1'b0, m2_addr_valid = 1'b0;
    logic       slave_ready_1 = 1'b1, slave_ready_2 = 1'b1, slave_ready_3 = 1'b1;
    logic [1:0] bus_grant;
    logic [2:0] slave_grant;
    logic       addr_err;
    logic       arb_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .m1_req        (m1_req),
        .m2_req        (m2_req),
        .m1_addr       (m1_addr),
        .m2_addr       (m2_addr),
        .m1_addr_valid (m1_addr_valid),
        .m2_addr_valid (m2_addr_valid),
        .slave_ready_1 (slave_ready_1),
        .slave_ready_2 (slave_ready_2),
        .slave_ready_3 (slave_ready_3),
        .bus_grant     (bus_grant),
        .slave_grant   (slave_grant),
        .addr_err      (addr_err),
        .arb_timeout   (arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] bg, input logic [2:0] sg,
                           input logic ae, input logic at);
        chk({tag, ".bus_grant"},   {2'b00, bus_grant},   {2'b00, bg});
        chk({tag, ".slave_grant"}, {1'b0, slave_grant},  {1'b0, sg});
        chk({tag, ".addr_err"},    {3'b000, addr_err},   {3'b000, ae});
        chk({tag, ".arb_timeout"}, {3'b000, arb_timeout}, {3'b000, at});
    endtask

    // Drive one address bit on master 1 (sel=0) or master 2 (sel=1) and clock it.
    task automatic send_bit(input logic sel, input logic b);
        if (sel) begin m2_addr = b; m2_addr_valid = 1'b1; end
        else     begin m1_addr = b; m1_addr_valid = 1'b1; end
        step();
        m1_addr_valid = 1'b0;
        m2_addr_valid = 1'b0;
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_all("reset", 2'b00, 3'b000, 1'b0, 1'b0);
        rstn = 1'b1;

        // M1 to slave 2, other master's address lines toggling
        m1_req = 1'b1;
        m2_addr = 1'b1; m2_addr_valid = 1'b1;
        step();
        chk_all("t1.grant", 2'b01, 3'b000, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("t1.bit1", {1'b0, slave_grant}, 4'h0);
        send_bit(1'b0, 1'b0);
        chk_all("t1.connect", 2'b01, 3'b101, 1'b0, 1'b0);
        step();
        chk_all("t1.hold", 2'b01, 3'b101, 1'b0, 1'b0);
        m1_req = 1'b0;
        step();
        chk_all("t1.release", 2'b00, 3'b000, 1'b0, 1'b0);

        // M2 address 00: error pulse, no regrant until released
        m2_req = 1'b1;
        step();
        chk("t3.grant", {2'b00, bus_grant}, 4'h2);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk_all("t3.err", 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        chk_all("t3.err_end", 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        chk("t3.wait", {2'b00, bus_grant}, 4'h0);
        m2_req = 1'b0;
        step();
        chk("t3.idle", {2'b00, bus_grant}, 4'h0);
        m2_req = 1'b1;
        step();
        chk("t3.regrant", {2'b00, bus_grant}, 4'h2);
        m2_req = 1'b0;
        step();
        chk_all("t3.drop_addr", 2'b00, 3'b000, 1'b0, 1'b0);

        // Gapped address 11
        m1_req = 1'b1;
        step();
        send_bit(1'b0, 1'b1);
        step(); step(); step();
        chk("t4.gap", {1'b0, slave_grant}, 4'h0);
        send_bit(1'b0, 1'b1);
        chk_all("t4.connect", 2'b01, 3'b111, 1'b0, 1'b0);

        // Default build: no timeout even with slave 3 never ready
`ifndef ARB_TIMEOUT_EN
        slave_ready_3 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk_all("t5.no_timeout", 2'b01, 3'b111, 1'b0, 1'b0);
        slave_ready_3 = 1'b1;
`endif
        m1_req = 1'b0;
        step();
        chk_all("t4.release", 2'b00, 3'b000, 1'b0, 1'b0);

        // Drop on the same edge as the second bit: drop wins
        m1_req = 1'b1;
        step();
        send_bit(1'b0, 1'b1);
        m1_req = 1'b0;
        send_bit(1'b0, 1'b1);
        chk_all("t4.drop_wins", 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        chk("t4.idle", {1'b0, slave_grant}, 4'h0);

`ifdef ARB_TIMEOUT_EN
        // Timeout after 4 not-ready cycles on slave 3
        m1_req = 1'b1;
        step();
        send_bit(1'b0, 1'b1);
        slave_ready_3 = 1'b0;
        send_bit(1'b0, 1'b1);
        chk("t5.connect", {1'b0, slave_grant}, 4'h7);
        step(); step(); step();
        chk("t5.pre", {3'b000, arb_timeout}, 4'h0);
        step();
        chk_all("t5.fire", 2'b00, 3'b000, 1'b0, 1'b1);
        step();
        chk("t5.pulse_end", {3'b000, arb_timeout}, 4'h0);
        m1_req = 1'b0;
        step();
        // Ready-high at cycle 3 restarts the count
        m1_req = 1'b1;
        step();
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        step(); step();
        slave_ready_3 = 1'b1;
        step();
        slave_ready_3 = 1'b0;
        step(); step(); step();
        chk_all("t5.restart_pre", 2'b01, 3'b111, 1'b0, 1'b0);
        step();
        chk_all("t5.restart_fire", 2'b00, 3'b000, 1'b0, 1'b1);
        m1_req = 1'b0;
        slave_ready_3 = 1'b1;
        step();
        step();
`endif

        // Round robin from reset: M1, M2, M1
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        m1_req = 1'b1; m2_req = 1'b1;
        step();
        chk("t2.rr1", {2'b00, bus_grant}, 4'h1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("t2.rr1_conn", {1'b0, slave_grant}, 4'h3);
        m1_req = 1'b0; m2_req = 1'b0;
        step();
        m1_req = 1'b1; m2_req = 1'b1;
        step();
        chk("t2.rr2", {2'b00, bus_grant}, 4'h2);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("t2.rr2_conn", {1'b0, slave_grant}, 4'h5);
        m1_req = 1'b0; m2_req = 1'b0;
        step();
        m1_req = 1'b1; m2_req = 1'b1;
        step();
        chk("t2.rr3", {2'b00, bus_grant}, 4'h1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        chk_all("t6.connect", 2'b01, 3'b111, 1'b0, 1'b0);

        // Async reset mid-connection, then M1 wins again
        #2;
        rstn = 1'b0;
        #1;
        chk_all("t6.async_reset", 2'b00, 3'b000, 1'b0, 1'b0);
        #1;
        rstn = 1'b1;
        step();
        chk("t6.rr_after_reset", {2'b00, bus_grant}, 4'h1);
        m1_req = 1'b0; m2_req = 1'b0;
        step();
        chk("t6.release", {2'b00, bus_grant}, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
